// File: rtl/uart_rx_fifo.sv
// Receive-side show-ahead byte FIFO between the UART receiver and the register interface.
// Provides level/threshold status, a sticky overflow flag and a registered RX interrupt.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          rx_valid_i,
  input  logic [7:0]    rx_byte_i,
  input  logic          pop_i,
  output logic [7:0]    rdata_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [AW:0]   level_o,
  input  logic [AW:0]   thresh_i,
  output logic          intr_rx_o,
  output logic          overflow_o,
  input  logic          clr_overflow_i,
  input  logic          flush_i
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        r_overflow;
  logic        r_intr;

  logic [AW:0] w_level;
  logic        w_empty;
  logic        w_full;
  logic        w_push_ok;
  logic        w_pop_ok;
  logic        w_drop;
  logic [AW:0] w_wptr_n;
  logic [AW:0] w_rptr_n;
  logic [AW:0] w_level_n;

  // Handshake: rx_valid_i is a one-cycle, unstallable byte strobe (no ready back to the
  // receiver; a byte arriving while full without a same-cycle pop is dropped and flagged).
  // pop_i consumes the show-ahead head entry; popping an empty FIFO is a silent no-op.
  assign w_level   = r_wptr - r_rptr;
  assign w_empty   = (w_level == '0);
  assign w_full    = (w_level == DEPTH_L);
  assign w_push_ok = !flush_i && rx_valid_i && (!w_full || pop_i);
  assign w_pop_ok  = !flush_i && pop_i && !w_empty;
  assign w_drop    = !flush_i && rx_valid_i && w_full && !pop_i;

  always_comb begin
    w_wptr_n = r_wptr;
    w_rptr_n = r_rptr;
    if (flush_i) begin
      w_rptr_n = r_wptr;
    end else begin
      if (w_push_ok) w_wptr_n = r_wptr + 1'b1;
      if (w_pop_ok)  w_rptr_n = r_rptr + 1'b1;
    end
  end

  assign w_level_n = w_wptr_n - w_rptr_n;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
      r_intr     <= 1'b0;
    end else begin
      r_wptr <= w_wptr_n;
      r_rptr <= w_rptr_n;
      // A new drop outranks a same-cycle clear so no overflow event is lost.
      if (w_drop)              r_overflow <= 1'b1;
      else if (clr_overflow_i) r_overflow <= 1'b0;
      r_intr <= (thresh_i != '0) && (w_level_n >= thresh_i);
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_push_ok) r_mem[r_wptr[AW-1:0]] <= rx_byte_i;
  end

  assign rdata_o    = w_empty ? 8'h00 : r_mem[r_rptr[AW-1:0]];
  assign empty_o    = w_empty;
  assign full_o     = w_full;
  assign level_o    = w_level;
  assign intr_rx_o  = r_intr;
  assign overflow_o = r_overflow;

endmodule
